// File: rtl/gates_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gates_pipe
// Description : Two-stage pipelined bitwise logic unit. Applies one of seven
//               bitwise operations (AND, OR, NOT, NAND, NOR, XOR, XNOR) to two
//               WIDTH-bit operands selected by a per-transaction opcode.
//               Opcode 7 is illegal: it yields y=0, zero=1, err=1.
//               Valid/ready handshake on both sides, one result per cycle.
//
// Ports       : clk        - clock, rising-edge active
//               rst_n      - asynchronous active-low reset
//               in_valid   - operand/opcode presented
//               in_ready   - input accepted this cycle (combinational)
//               a, b       - operands (b ignored for NOT)
//               op         - opcode 0..7
//               out_valid  - result valid
//               out_ready  - consumer accepts result
//               y          - result
//               y_op       - opcode that produced y
//               zero       - y == 0
//               err        - opcode was 7
//               red_and/red_or/red_xor - reductions of y (only when
//                            GATES_PIPE_REDUCE_EN is defined)
//
// Options     : `define GATES_PIPE_REDUCE_EN to add the reduction outputs.
//
// Revision    : 1.0 - initial release
// ============================================================================
module gates_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef GATES_PIPE_REDUCE_EN
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor,
`endif
    output logic [WIDTH-1:0] y,
    output logic [2:0]       y_op,
    output logic             zero,
    output logic             err
);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_NOT  = 3'd2;
    localparam logic [2:0] c_OP_NAND = 3'd3;
    localparam logic [2:0] c_OP_NOR  = 3'd4;
    localparam logic [2:0] c_OP_XOR  = 3'd5;
    localparam logic [2:0] c_OP_XNOR = 3'd6;
    localparam logic [2:0] c_OP_ILL  = 3'd7;

    // Stage-1 (operand) registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;

    // Stage-2 (result) registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic [2:0]       r_y_op;
    logic             r_zero;
    logic             r_err;

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [WIDTH-1:0] w_y;
    logic             w_zero;
    logic             w_err;

    // A stage may advance when it is empty or its downstream is advancing,
    // so bubbles collapse even while the consumer stalls.
    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_comb begin
        w_y = '0;
        case (r_s1_op)
            c_OP_AND:  w_y = r_s1_a & r_s1_b;
            c_OP_OR:   w_y = r_s1_a | r_s1_b;
            c_OP_NOT:  w_y = ~r_s1_a;
            c_OP_NAND: w_y = ~(r_s1_a & r_s1_b);
            c_OP_NOR:  w_y = ~(r_s1_a | r_s1_b);
            c_OP_XOR:  w_y = r_s1_a ^ r_s1_b;
            c_OP_XNOR: w_y = ~(r_s1_a ^ r_s1_b);
            default:   w_y = '0;
        endcase
    end

    assign w_zero = (w_y == '0);
    assign w_err  = (r_s1_op == c_OP_ILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_op     <= '0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_y_op      <= '0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_a  <= a;
                    r_s1_b  <= b;
                    r_s1_op <= op;
                end
            end
            // Result payload only loads with a real transaction; a bubble
            // clears out_valid but leaves the last result visible.
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_y    <= w_y;
                    r_y_op <= r_s1_op;
                    r_zero <= w_zero;
                    r_err  <= w_err;
                end
            end
        end
    end

`ifdef GATES_PIPE_REDUCE_EN
    logic r_red_and;
    logic r_red_or;
    logic r_red_xor;

    // Illegal opcode gives w_y == 0, so all three reductions come out 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_red_and <= 1'b0;
            r_red_or  <= 1'b0;
            r_red_xor <= 1'b0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_red_and <= &w_y;
            r_red_or  <= |w_y;
            r_red_xor <= ^w_y;
        end
    end

    assign red_and = r_red_and;
    assign red_or  = r_red_or;
    assign red_xor = r_red_xor;
`endif

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign y_op      = r_y_op;
    assign zero      = r_zero;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gates_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_gates_pipe
// Description : Self-checking bench for gates_pipe (WIDTH=8). A reference
//               model computes the expected result when an input transfer
//               happens; a scoreboard queue compares it when the output
//               transfers. Directed checks cover reset, latency, streaming,
//               backpressure and flags. Reduction outputs are exercised when
//               GATES_PIPE_REDUCE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gates_pipe;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [2:0]       y_op;
    logic             zero;
    logic             err;
`ifdef GATES_PIPE_REDUCE_EN
    logic             red_and;
    logic             red_or;
    logic             red_xor;
`endif

    gates_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef GATES_PIPE_REDUCE_EN
        .red_and   (red_and),
        .red_or    (red_or),
        .red_xor   (red_xor),
`endif
        .y         (y),
        .y_op      (y_op),
        .zero      (zero),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic [2:0]       op;
        logic             zero;
        logic             err;
        logic             rand_;
        logic             ror;
        logic             rxor;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic [2:0] mop);
        exp_t e;
        case (mop)
            3'd0:    e.y = ma & mb;
            3'd1:    e.y = ma | mb;
            3'd2:    e.y = ~ma;
            3'd3:    e.y = ~(ma & mb);
            3'd4:    e.y = ~(ma | mb);
            3'd5:    e.y = ma ^ mb;
            3'd6:    e.y = ~(ma ^ mb);
            default: e.y = '0;
        endcase
        e.op    = mop;
        e.zero  = (e.y == '0);
        e.err   = (mop == 3'd7);
        e.rand_ = &e.y;
        e.ror   = |e.y;
        e.rxor  = ^e.y;
        return e;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                sb.push_back(model(a, b, op));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("y",    32'(y),    32'(e.y));
                    check("y_op", 32'(y_op), 32'(e.op));
                    check("zero", 32'(zero), 32'(e.zero));
                    check("err",  32'(err),  32'(e.err));
`ifdef GATES_PIPE_REDUCE_EN
                    check("red_and", 32'(red_and), 32'(e.rand_));
                    check("red_or",  32'(red_or),  32'(e.ror));
                    check("red_xor", 32'(red_xor), 32'(e.rxor));
`endif
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one transaction and hold it until it is accepted.
    task automatic drive(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                         input logic [2:0] dop);
        logic acc;
        int   n;
        in_valid = 1'b1;
        a        = da;
        b        = db;
        op       = dop;
        n        = 0;
        acc      = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        check("accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        a        = $urandom_range(0, 255);
        b        = $urandom_range(0, 255);
        op       = 3'($urandom_range(0, 7));
    endtask

    initial begin
        logic [WIDTH-1:0] hold;
        logic             have;
        int               acc_cnt;
        int               n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y",         32'(y),         32'd0);
        check("rst_zero",      32'(zero),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op latency: result 2 edges after acceptance
        sync();
        drive(8'hA5, 8'h0F, 3'd0);
        check("lat_edge1", 32'(out_valid), 32'd0);
        sync();
        check("lat_edge2", 32'(out_valid), 32'd1);
        check("lat_y",     32'(y),         32'h05);
        repeat (2) sync();

        // Back-to-back stream of ops 0..6
        fork
            begin
                for (int i = 0; i < 7; i++)
                    drive(8'hA5, 8'h0F, 3'(i));
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 7; i++) begin
                    check("b2b_valid", 32'(out_valid), 32'd1);
                    @(negedge clk);
                end
            end
        join
        repeat (3) sync();

        // Flags: XOR to zero, then illegal opcode
        drive(8'hFF, 8'hFF, 3'd5);
        drive(8'h3C, 8'hC3, 3'd7);
        repeat (3) sync();

        // Reduction case (XOR -> 8'hAA) and a few random transactions
        drive(8'hA5, 8'h0F, 3'd5);
        for (int i = 0; i < 6; i++)
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        repeat (3) sync();

        // Backpressure: consumer stalls 5 cycles against a continuous stream
        out_ready = 1'b0;
        acc_cnt   = 0;
        have      = 1'b0;
        hold      = '0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive(8'(8'h11 * i), 8'hF0, 3'(i % 8));
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (in_valid && in_ready)
                        acc_cnt++;
                    if (out_valid) begin
                        if (!have) begin
                            hold = y;
                            have = 1'b1;
                        end else begin
                            check("stall_hold_y", 32'(y), 32'(hold));
                        end
                    end
                end
                check("stall_accepts",  32'(acc_cnt),  32'd2);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                sync();
                out_ready = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    check("release_valid", 32'(out_valid), 32'd1);
                end
            end
        join
        repeat (3) sync();

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            sync();
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);

        // Reset mid-operation
        out_ready = 1'b0;
        drive(8'hFF, 8'h00, 3'd1);
        drive(8'h00, 8'h00, 3'd7);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_y",     32'(y),         32'hFF);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_y",     32'(y),         32'd0);
        check("midrst_err",   32'(err),       32'd0);
        check("midrst_y_op",  32'(y_op),      32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        sync();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
